cpu3: RTL and testbench

- Next-generation parametrised accumulator processor core.
- Single multi-cycle FSM replaces the separate sequencer/IR/PC/ALU blocks.
- Talks to external program/data memory through a req/ack handshake with arbitrary wait states.
- Adds XOR, conditional branch, switch/display I/O and HALT for the XOR encrypt/decrypt application. Sits directly under the board top level.

---
 rtl/cpu3_pkg.sv | 36 +++
 rtl/cpu3_alu.sv | 26 ++
 rtl/cpu3.sv | 194 +++++++++++++++++++
 tb/tb_cpu3.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu3_pkg.sv
// cpu3_pkg: shared opcode/state types and I/O select constants for the cpu3 core.
package cpu3_pkg;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'd0,
        OP_STORE = 3'd1,
        OP_ADD   = 3'd2,
        OP_SUB   = 3'd3,
        OP_XOR   = 3'd4,
        OP_BNZ   = 3'd5,
        OP_IO    = 3'd6,
        OP_HALT  = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        MEM    = 2'd2,
        HALTED = 2'd3
    } state_e;

    // Address bit 0 of an IO instruction picks the direction.
    localparam logic IO_IN  = 1'b0;
    localparam logic IO_OUT = 1'b1;

    // True for opcodes that need a second memory access for their operand.
    function automatic logic needs_mem(input opcode_e op);
        logic r;
        case (op)
            OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_XOR: r = 1'b1;
            default:                                    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpu3_alu.sv
// cpu3_alu: combinational accumulator update for the memory-operand opcodes.
// Arithmetic wraps modulo 2^WORD_W; carry and borrow are dropped.
module cpu3_alu
    import cpu3_pkg::*;
#(
    parameter int WORD_W = 10
) (
    input  opcode_e            op,
    input  logic [WORD_W-1:0]  acc,
    input  logic [WORD_W-1:0]  operand,
    output logic [WORD_W-1:0]  result
);

    // Select the new accumulator value; non-ALU opcodes leave it unchanged.
    always_comb begin
        result = acc;
        case (op)
            OP_LOAD: result = operand;
            OP_ADD:  result = acc + operand;
            OP_SUB:  result = acc - operand;
            OP_XOR:  result = acc ^ operand;
            default: result = acc;
        endcase
    end

endmodule

// File: rtl/cpu3.sv
// cpu3: multi-cycle accumulator core with a req/ack memory port.
// One FSM (FETCH/DECODE/MEM/HALTED) sequences fetch, decode and operand access.
// All memory-port outputs are registered so they stay frozen through wait states.
module cpu3
    import cpu3_pkg::*;
#(
    parameter  int WORD_W = 10,
    parameter  int OP_W   = 3,
    localparam int ADDR_W = WORD_W - OP_W
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] switches,
    output logic [WORD_W-1:0] display,
    output logic              z_flag,
    output logic              halted
);

    state_e              state_r, state_s;
    logic [ADDR_W-1:0]   pc_r, pc_s;
    logic [WORD_W-1:0]   ir_r, ir_s;
    logic [WORD_W-1:0]   acc_r, acc_s;
    logic [WORD_W-1:0]   display_r, display_s;
    logic                mem_req_r, mem_req_s;
    logic                mem_we_r, mem_we_s;
    logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
    logic [WORD_W-1:0]   mem_wdata_r, mem_wdata_s;
    logic                halted_r, halted_s;

    opcode_e             op_s;
    logic [ADDR_W-1:0]   opnd_s;
    logic [WORD_W-1:0]   alu_res_s;
    logic                ack_s;
    logic                acc_nz_s;

    assign op_s     = opcode_e'(ir_r[WORD_W-1:ADDR_W]);
    assign opnd_s   = ir_r[ADDR_W-1:0];
    // An ack only counts while a request is actually outstanding.
    assign ack_s    = mem_ack & mem_req_r;
    assign acc_nz_s = (acc_r != {WORD_W{1'b0}});

    cpu3_alu #(
        .WORD_W (WORD_W)
    ) u_alu (
        .op      (op_s),
        .acc     (acc_r),
        .operand (mem_rdata),
        .result  (alu_res_s)
    );

    // Next-state and next-register logic; every register holds unless told otherwise.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        ir_s        = ir_r;
        acc_s       = acc_r;
        display_s   = display_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        halted_s    = halted_r;

        case (state_r)
            FETCH: begin
                if (!mem_req_r) begin
                    // First cycle after reset: launch the instruction fetch.
                    mem_req_s   = 1'b1;
                    mem_we_s    = 1'b0;
                    mem_addr_s  = pc_r;
                    mem_wdata_s = acc_r;
                end else if (ack_s) begin
                    ir_s      = mem_rdata;
                    pc_s      = pc_r + ADDR_W'(1'b1);
                    mem_req_s = 1'b0;
                    mem_we_s  = 1'b0;
                    state_s   = DECODE;
                end else begin
                    state_s = FETCH;
                end
            end

            DECODE: begin
                if (needs_mem(op_s)) begin
                    state_s     = MEM;
                    mem_req_s   = 1'b1;
                    mem_we_s    = (op_s == OP_STORE);
                    mem_addr_s  = opnd_s;
                    mem_wdata_s = acc_r;
                end else if (op_s == OP_HALT) begin
                    state_s   = HALTED;
                    halted_s  = 1'b1;
                    mem_req_s = 1'b0;
                    mem_we_s  = 1'b0;
                end else begin
                    // BNZ and IO finish here and chain straight into the next fetch.
                    state_s     = FETCH;
                    mem_req_s   = 1'b1;
                    mem_we_s    = 1'b0;
                    mem_addr_s  = pc_r;
                    mem_wdata_s = acc_r;
                    case (op_s)
                        OP_BNZ: begin
                            if (acc_nz_s) begin
                                pc_s       = opnd_s;
                                mem_addr_s = opnd_s;
                            end else begin
                                pc_s       = pc_r;
                                mem_addr_s = pc_r;
                            end
                        end
                        OP_IO: begin
                            if (opnd_s[0] == IO_OUT) begin
                                display_s = acc_r;
                            end else begin
                                acc_s = switches;
                            end
                        end
                        default: begin
                            state_s = FETCH;
                        end
                    endcase
                end
            end

            MEM: begin
                if (ack_s) begin
                    acc_s       = (op_s == OP_STORE) ? acc_r : alu_res_s;
                    state_s     = FETCH;
                    mem_req_s   = 1'b1;
                    mem_we_s    = 1'b0;
                    mem_addr_s  = pc_r;
                    mem_wdata_s = acc_r;
                end else begin
                    state_s = MEM;
                end
            end

            HALTED: begin
                halted_s  = 1'b1;
                mem_req_s = 1'b0;
                mem_we_s  = 1'b0;
            end

            default: begin
                state_s   = FETCH;
                mem_req_s = 1'b0;
                mem_we_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; reset abandons any access.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= FETCH;
            pc_r        <= {ADDR_W{1'b0}};
            ir_r        <= {WORD_W{1'b0}};
            acc_r       <= {WORD_W{1'b0}};
            display_r   <= {WORD_W{1'b0}};
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {WORD_W{1'b0}};
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            ir_r        <= ir_s;
            acc_r       <= acc_s;
            display_r   <= display_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            halted_r    <= halted_s;
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign display   = display_r;
    assign halted    = halted_r;
    assign z_flag    = ~acc_nz_s;

endmodule

// File: tb/tb_cpu3.sv
// tb_cpu3: directed tests for cpu3 against a req/ack memory model with
// configurable wait states; each scenario task checks its own results.
module tb_cpu3;
    import cpu3_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ack;
    logic [6:0]  mem_addr;
    logic [9:0]  mem_wdata, mem_rdata;
    logic [9:0]  switches = 10'h000;
    logic [9:0]  display;
    logic        z_flag, halted;

    int errors = 0;
    int checks = 0;

    // Memory model state
    logic [9:0]  mem [0:127];
    int          wait_n = 0;
    int          cnt = 0;
    logic        late_ack = 1'b0;
    logic        clr = 1'b0;
    logic        ld_en = 1'b0;
    logic [6:0]  ld_addr = 7'h00;
    logic [9:0]  ld_data = 10'h000;

    cpu3 dut (
        .clock     (clock),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .switches  (switches),
        .display   (display),
        .z_flag    (z_flag),
        .halted    (halted)
    );

    always #5 clock = ~clock;

    assign mem_ack   = (mem_req && (cnt == wait_n)) || late_ack;
    assign mem_rdata = mem[mem_addr];

    // Memory model: preload/clear port, write on acked store, wait-state counter.
    always @(posedge clock) begin
        if (clr) begin
            for (int i = 0; i < 128; i++) mem[i] <= 10'h000;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (mem_req && mem_ack && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_req && mem_ack) cnt <= 0;
        else if (mem_req)       cnt <= cnt + 1;
        else                    cnt <= 0;
    end

    // Hold the core in reset and wipe memory (called on a negedge).
    task automatic start_prog(input int waits);
        reset = 1'b1;
        late_ack = 1'b0;
        wait_n = waits;
        clr = 1'b1;
        @(negedge clock);
        clr = 1'b0;
        @(negedge clock);
    endtask

    task automatic poke(input logic [6:0] a, input logic [9:0] d);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clock);
        ld_en = 1'b0;
    endtask

    // Advance n cycles, ending on the negedge after the n-th posedge.
    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset;
        start_prog(0);
        poke(7'h00, 10'h380);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", mem_we); end
        checks++; if (display !== 10'h000) begin errors++; $display("FAIL rst_display: got %h want 000", display); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b want 0", halted); end
        checks++; if (z_flag !== 1'b1) begin errors++; $display("FAIL rst_zflag: got %b want 1", z_flag); end
        checks++; if (dut.pc_r !== 7'h00) begin errors++; $display("FAIL rst_pc: got %h want 00", dut.pc_r); end
        checks++; if (dut.state_r !== FETCH) begin errors++; $display("FAIL rst_state: got %0d want FETCH", dut.state_r); end
        reset = 1'b0;
        cycles(1);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 7'h00 || mem_we !== 1'b0) begin
            errors++; $display("FAIL first_fetch: got req=%b addr=%h we=%b want 1/00/0", mem_req, mem_addr, mem_we);
        end
    endtask

    task automatic test_xor;
        start_prog(0);
        poke(7'h00, 10'h005);
        poke(7'h01, 10'h206);
        poke(7'h05, 10'h155);
        poke(7'h06, 10'h0FF);
        reset = 1'b0;
        cycles(6);
        checks++; if (dut.acc_r !== 10'h155) begin errors++; $display("FAIL xor_mid_acc: got %h want 155", dut.acc_r); end
        cycles(1);
        checks++; if (dut.acc_r !== 10'h1AA) begin errors++; $display("FAIL xor_acc: got %h want 1AA", dut.acc_r); end
        checks++; if (z_flag !== 1'b0) begin errors++; $display("FAIL xor_z: got %b want 0", z_flag); end
        checks++; if (dut.pc_r !== 7'h02) begin errors++; $display("FAIL xor_pc: got %h want 02", dut.pc_r); end
    endtask

    task automatic test_back_to_back;
        start_prog(0);
        poke(7'h00, 10'h010);
        poke(7'h01, 10'h111);
        poke(7'h02, 10'h191);
        poke(7'h10, 10'h3FF);
        poke(7'h11, 10'h001);
        reset = 1'b0;
        cycles(4);
        checks++; if (dut.acc_r !== 10'h3FF) begin errors++; $display("FAIL b2b_load: got %h want 3FF", dut.acc_r); end
        cycles(3);
        checks++; if (dut.acc_r !== 10'h000 || z_flag !== 1'b1) begin
            errors++; $display("FAIL b2b_add_wrap: got acc=%h z=%b want 000/1", dut.acc_r, z_flag);
        end
        cycles(3);
        checks++; if (dut.acc_r !== 10'h3FF || z_flag !== 1'b0) begin
            errors++; $display("FAIL b2b_sub_borrow: got acc=%h z=%b want 3FF/0", dut.acc_r, z_flag);
        end
    endtask

    task automatic test_wait_states;
        logic       prev_wait;
        logic [6:0] prev_addr;
        logic       prev_we;
        int         waits_seen;
        int         stab_bad;
        start_prog(3);
        poke(7'h00, 10'h005);
        poke(7'h01, 10'h206);
        poke(7'h05, 10'h155);
        poke(7'h06, 10'h0FF);
        reset = 1'b0;
        prev_wait = 1'b0;
        prev_addr = 7'h00;
        prev_we = 1'b0;
        waits_seen = 0;
        stab_bad = 0;
        for (int c = 1; c <= 19; c++) begin
            cycles(1);
            if (prev_wait && (mem_req !== 1'b1 || mem_addr !== prev_addr || mem_we !== prev_we)) stab_bad++;
            if (c <= 18 && mem_req && !mem_ack) waits_seen++;
            prev_wait = mem_req && !mem_ack;
            prev_addr = mem_addr;
            prev_we = mem_we;
            if (c == 18) begin
                checks++; if (dut.acc_r !== 10'h155) begin errors++; $display("FAIL ws_mid_acc: got %h want 155", dut.acc_r); end
            end
        end
        checks++; if (dut.acc_r !== 10'h1AA) begin errors++; $display("FAIL ws_acc: got %h want 1AA", dut.acc_r); end
        checks++; if (stab_bad !== 0) begin errors++; $display("FAIL ws_stable: got %0d unstable cycles want 0", stab_bad); end
        checks++; if (waits_seen !== 12) begin errors++; $display("FAIL ws_count: got %0d wait cycles want 12", waits_seen); end
    endtask

    task automatic test_io_store;
        start_prog(0);
        poke(7'h00, 10'h300);
        poke(7'h01, 10'h301);
        poke(7'h02, 10'h0A0);
        poke(7'h03, 10'h380);
        switches = 10'h2A5;
        reset = 1'b0;
        cycles(3);
        checks++; if (dut.acc_r !== 10'h2A5) begin errors++; $display("FAIL io_in: got %h want 2A5", dut.acc_r); end
        cycles(1);
        checks++; if (display !== 10'h000) begin errors++; $display("FAIL io_out_early: got %h want 000", display); end
        cycles(1);
        checks++; if (display !== 10'h2A5) begin errors++; $display("FAIL io_out: got %h want 2A5", display); end
        cycles(2);
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 7'h20 || mem_wdata !== 10'h2A5) begin
            errors++; $display("FAIL store_port: got req=%b we=%b addr=%h wdata=%h want 1/1/20/2A5", mem_req, mem_we, mem_addr, mem_wdata);
        end
        cycles(1);
        checks++; if (mem[7'h20] !== 10'h2A5) begin errors++; $display("FAIL store_mem: got %h want 2A5", mem[7'h20]); end
        cycles(4);
        checks++; if (halted !== 1'b1 || mem_req !== 1'b0 || display !== 10'h2A5) begin
            errors++; $display("FAIL io_halt: got halted=%b req=%b display=%h want 1/0/2A5", halted, mem_req, display);
        end
        switches = 10'h000;
    endtask

    task automatic test_loop_wrap;
        int         n00, n03, n7f, req_bad, wrap_bad;
        logic [6:0] prev_rd;
        logic       have_prev;
        start_prog(0);
        poke(7'h00, 10'h283);
        poke(7'h01, 10'h051);
        poke(7'h02, 10'h2FF);
        poke(7'h03, 10'h1D1);
        poke(7'h04, 10'h283);
        poke(7'h05, 10'h380);
        poke(7'h51, 10'h001);
        poke(7'h7F, 10'h300);
        switches = 10'h003;
        reset = 1'b0;
        n00 = 0; n03 = 0; n7f = 0; req_bad = 0; wrap_bad = 0;
        prev_rd = 7'h00;
        have_prev = 1'b0;
        for (int c = 0; c < 300 && !halted; c++) begin
            @(negedge clock);
            if (mem_req && mem_ack && !mem_we) begin
                if (have_prev && prev_rd == 7'h7F && mem_addr !== 7'h00) wrap_bad++;
                if (mem_addr == 7'h00) n00++;
                if (mem_addr == 7'h03) n03++;
                if (mem_addr == 7'h7F) n7f++;
                prev_rd = mem_addr;
                have_prev = 1'b1;
            end
        end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL loop_halted: got %b want 1 (cycle budget)", halted); end
        checks++; if (n03 !== 3) begin errors++; $display("FAIL loop_iters: got %0d want 3", n03); end
        checks++; if (n7f !== 1 || n00 !== 2 || wrap_bad !== 0) begin
            errors++; $display("FAIL pc_wrap: got n7f=%0d n00=%0d bad=%0d want 1/2/0", n7f, n00, wrap_bad);
        end
        checks++; if (z_flag !== 1'b1 || dut.pc_r !== 7'h06) begin
            errors++; $display("FAIL loop_end: got z=%b pc=%h want 1/06", z_flag, dut.pc_r);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (mem_req !== 1'b0 || halted !== 1'b1) req_bad++;
        end
        checks++; if (req_bad !== 0) begin errors++; $display("FAIL halt_hold: got %0d bad cycles want 0", req_bad); end
        switches = 10'h000;
    endtask

    task automatic test_reset_mid_txn;
        bit found;
        start_prog(3);
        poke(7'h00, 10'h300);
        poke(7'h01, 10'h301);
        poke(7'h02, 10'h005);
        poke(7'h05, 10'h155);
        switches = 10'h123;
        reset = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clock);
            if (mem_req && mem_addr == 7'h05 && !mem_ack) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rmt_reach: got no MEM wait want one (cycle budget)"); end
        checks++; if (display !== 10'h123) begin errors++; $display("FAIL rmt_display_pre: got %h want 123", display); end
        reset = 1'b1;
        @(negedge clock);
        checks++; if (mem_req !== 1'b0 || dut.pc_r !== 7'h00 || z_flag !== 1'b1 || display !== 10'h000) begin
            errors++; $display("FAIL rmt_reset: got req=%b pc=%h z=%b display=%h want 0/00/1/000", mem_req, dut.pc_r, z_flag, display);
        end
        checks++; if (dut.state_r !== FETCH || halted !== 1'b0) begin
            errors++; $display("FAIL rmt_state: got state=%0d halted=%b want FETCH/0", dut.state_r, halted);
        end
        reset = 1'b0;
        late_ack = 1'b1;
        @(negedge clock);
        late_ack = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 7'h00 || dut.pc_r !== 7'h00 || dut.ir_r !== 10'h000 || z_flag !== 1'b1) begin
            errors++; $display("FAIL rmt_late_ack: got req=%b addr=%h pc=%h ir=%h z=%b want 1/00/00/000/1",
                               mem_req, mem_addr, dut.pc_r, dut.ir_r, z_flag);
        end
        switches = 10'h000;
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_xor();
        test_back_to_back();
        test_wait_states();
        test_io_store();
        test_loop_wrap();
        test_reset_mid_txn();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
